// File: rtl/uart_frame_decoder_pkg.sv
// Shared definitions for the UART command-frame decoder and its matching encoder.
package uart_frame_decoder_pkg;

   typedef enum logic [1:0] {
      HUNT = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      CHK  = 2'd3
   } frame_state_t;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h55;

   // A byte-time is 10 bit periods: start bit, 8 data bits and the stop bit.
   function automatic int timeout_clks(input int clk_freq, input int baud_rate,
                                       input int timeout_bytes);
      return (clk_freq / baud_rate) * 10 * timeout_bytes;
   endfunction

endpackage

// File: rtl/uart_frame_decoder_gap.sv
// Inter-byte gap timer: counts idle cycles mid-frame and pulses expire when the limit is reached.
module uart_gap_timer #(
   parameter int TIMEOUT_CLKS = 40
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int CNT_W = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CLKS - 1);

   logic [CNT_W-1:0] count_q, count_d;

   // An accepted byte always beats an expiry landing on the same cycle.
   assign expire = enable && !clear && (count_q == LAST);

   always_comb begin
      count_d = count_q + 1'b1;
      if (!enable || clear || expire) begin
         count_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/uart_frame_decoder.sv
// Assembles SYNC/ADDR/DATA/CHK frames from the UART byte strobe into register-write commands.
//  state | meaning
//  HUNT  | idle, discarding bytes until SYNC_BYTE
//  ADDR  | expecting address byte
//  DATA  | expecting data byte
//  CHK   | expecting checksum byte (addr + data, mod 256)
module uart_frame_decoder
   import uart_frame_decoder_pkg::*;
#(
   parameter int         CLK_FREQ      = 50000000,
   parameter int         BAUD_RATE     = 115200,
   parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEFAULT,
   parameter int         TIMEOUT_BYTES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_ready,
   input  logic [7:0] rx_data,
   output logic       cmd_valid,
   output logic [7:0] cmd_addr,
   output logic [7:0] cmd_data,
   output logic       chk_err,
   output logic       timeout_err,
   output logic [7:0] err_count,
   output logic       busy
);

   localparam int TIMEOUT_CLKS = timeout_clks(CLK_FREQ, BAUD_RATE, TIMEOUT_BYTES);

   frame_state_t state_q, state_d;
   logic [7:0]   addr_reg_q, addr_reg_d;
   logic [7:0]   data_reg_q, data_reg_d;
   logic [7:0]   sum_q, sum_d;
   logic [7:0]   cmd_addr_q, cmd_addr_d;
   logic [7:0]   cmd_data_q, cmd_data_d;
   logic [7:0]   err_count_q, err_count_d;
   logic         cmd_valid_q, cmd_valid_d;
   logic         chk_err_q, chk_err_d;
   logic         timeout_err_q, timeout_err_d;
   logic         busy_q, busy_d;
   logic         gap_expire;

   uart_gap_timer #(
      .TIMEOUT_CLKS(TIMEOUT_CLKS)
   ) u_gap_timer (
      .clk   (clk),
      .rst   (rst),
      .clear (rx_ready),
      .enable(state_q != HUNT),
      .expire(gap_expire)
   );

   always_comb begin
      state_d       = state_q;
      addr_reg_d    = addr_reg_q;
      data_reg_d    = data_reg_q;
      sum_d         = sum_q;
      cmd_addr_d    = cmd_addr_q;
      cmd_data_d    = cmd_data_q;
      cmd_valid_d   = 1'b0;
      chk_err_d     = 1'b0;
      timeout_err_d = 1'b0;

      if (rx_ready) begin
         case (state_q)
            HUNT: begin
               if (rx_data == SYNC_BYTE) begin
                  state_d = ADDR;
               end
            end
            ADDR: begin
               addr_reg_d = rx_data;
               sum_d      = rx_data;
               state_d    = DATA;
            end
            DATA: begin
               data_reg_d = rx_data;
               sum_d      = sum_q + rx_data;
               state_d    = CHK;
            end
            CHK: begin
               if (rx_data == sum_q) begin
                  cmd_valid_d = 1'b1;
                  cmd_addr_d  = addr_reg_q;
                  cmd_data_d  = data_reg_q;
               end else begin
                  chk_err_d = 1'b1;
               end
               state_d = HUNT;
            end
            default: state_d = HUNT;
         endcase
      end else if (gap_expire) begin
         timeout_err_d = 1'b1;
         state_d       = HUNT;
      end

      err_count_d = err_count_q;
      if ((chk_err_d || timeout_err_d) && (err_count_q != 8'hFF)) begin
         err_count_d = err_count_q + 8'd1;
      end

      busy_d = (state_d != HUNT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= HUNT;
         addr_reg_q    <= '0;
         data_reg_q    <= '0;
         sum_q         <= '0;
         cmd_addr_q    <= '0;
         cmd_data_q    <= '0;
         err_count_q   <= '0;
         cmd_valid_q   <= 1'b0;
         chk_err_q     <= 1'b0;
         timeout_err_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         addr_reg_q    <= addr_reg_d;
         data_reg_q    <= data_reg_d;
         sum_q         <= sum_d;
         cmd_addr_q    <= cmd_addr_d;
         cmd_data_q    <= cmd_data_d;
         err_count_q   <= err_count_d;
         cmd_valid_q   <= cmd_valid_d;
         chk_err_q     <= chk_err_d;
         timeout_err_q <= timeout_err_d;
         busy_q        <= busy_d;
      end
   end

   assign cmd_valid   = cmd_valid_q;
   assign cmd_addr    = cmd_addr_q;
   assign cmd_data    = cmd_data_q;
   assign chk_err     = chk_err_q;
   assign timeout_err = timeout_err_q;
   assign err_count   = err_count_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Bench for uart_frame_decoder: directed and random byte streams checked every cycle against a frame-level model.
module tb_uart_frame_decoder;

   localparam int BAUD = 115200;
   localparam int CLKF = BAUD * 4;
   localparam int T    = 40;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_ready = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       cmd_valid, chk_err, timeout_err, busy;
   logic [7:0] cmd_addr, cmd_data, err_count;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Model state: bytes of the frame in progress (SYNC included) and idle cycles since the last byte.
   logic [7:0] frame[$];
   int         gap = 0;
   logic [7:0] m_addr = 0, m_data = 0, m_err = 0;
   logic       m_cv = 0, m_ce = 0, m_to = 0;

   uart_frame_decoder #(
      .CLK_FREQ     (CLKF),
      .BAUD_RATE    (BAUD),
      .SYNC_BYTE    (8'h55),
      .TIMEOUT_BYTES(1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_ready   (rx_ready),
      .rx_data    (rx_data),
      .cmd_valid  (cmd_valid),
      .cmd_addr   (cmd_addr),
      .cmd_data   (cmd_data),
      .chk_err    (chk_err),
      .timeout_err(timeout_err),
      .err_count  (err_count),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic void bump_err();
      if (m_err != 8'hFF) m_err = m_err + 8'd1;
   endfunction

   task automatic model(input logic r, input logic [7:0] d, input logic rs);
      logic [8:0] s;
      m_cv = 0; m_ce = 0; m_to = 0;
      if (rs) begin
         frame.delete(); gap = 0;
         m_addr = 0; m_data = 0; m_err = 0;
      end else if (r) begin
         gap = 0;
         if (frame.size() != 0 || d == 8'h55) frame.push_back(d);
         if (frame.size() == 4) begin
            s = frame[1] + frame[2];
            if (d == s[7:0]) begin
               m_cv = 1; m_addr = frame[1]; m_data = frame[2];
            end else begin
               m_ce = 1; bump_err();
            end
            frame.delete();
         end
      end else if (frame.size() != 0) begin
         gap++;
         if (gap == T) begin
            m_to = 1; bump_err(); frame.delete(); gap = 0;
         end
      end
   endtask

   task automatic step(input logic r, input logic [7:0] d, input logic rs);
      rx_ready = r; rx_data = d; rst = rs;
      @(posedge clk);
      cyc++;
      model(r, d, rs);
      #1;
      chk("cmd_valid", cmd_valid, m_cv);
      chk("chk_err", chk_err, m_ce);
      chk("timeout_err", timeout_err, m_to);
      chk("busy", busy, frame.size() != 0);
      chk("cmd_addr", cmd_addr, m_addr);
      chk("cmd_data", cmd_data, m_data);
      chk("err_count", err_count, m_err);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
   endtask

   task automatic send(input logic [7:0] b, input int space);
      step(1'b1, b, 1'b0);
      idle(space);
   endtask

   initial begin
      logic [7:0] a, dv, c, nz;
      // reset state
      step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b1);
      idle(3);

      // good frame
      send(8'h55, 19); send(8'h12, 19); send(8'h34, 19); send(8'h46, 19);
      // bad checksum
      send(8'h55, 19); send(8'h12, 19); send(8'h34, 19); send(8'h47, 19);
      // leading noise and in-frame sync
      send(8'h00, 2); send(8'hFF, 2); send(8'h55, 2); send(8'h55, 2);
      send(8'h55, 2); send(8'hAA, 5);

      // timeout then recovery
      send(8'h55, 3); send(8'h12, T + 5);
      send(8'h55, 1); send(8'h01, 1); send(8'h02, 1); send(8'h03, 3);
      // strobe landing on the expiry cycle
      send(8'h55, 2); send(8'h10, T - 1); send(8'h20, T - 1); send(8'h30, 4);

      // reset mid-frame
      send(8'h55, 2); send(8'h12, 2);
      step(1'b0, 8'h00, 1'b1);
      idle(2);
      send(8'h55, 1); send(8'h12, 1); send(8'h34, 1); send(8'h46, 3);

      // random frames, gaps and noise
      for (int f = 0; f < 40; f++) begin
         nz = 8'($urandom_range(0, 255));
         if (nz == 8'h55) nz = 8'h00;
         if ($urandom_range(0, 3) == 0) send(nz, $urandom_range(0, 3));
         a  = 8'($urandom);
         dv = 8'($urandom);
         c  = a + dv;
         if ($urandom_range(0, 3) == 0) c = c ^ 8'($urandom_range(1, 255));
         send(8'h55, $urandom_range(0, 10));
         send(a,  ($urandom_range(0, 7) == 0) ? $urandom_range(T - 2, T + 2) : $urandom_range(0, 10));
         send(dv, $urandom_range(0, 10));
         send(c,  $urandom_range(0, 4));
      end

      // saturation
      for (int f = 0; f < 260; f++) begin
         send(8'h55, 0); send(8'h00, 0); send(8'h00, 0); send(8'h01, 1);
      end
      send(8'h55, 0); send(8'h21, 0); send(8'h43, 0); send(8'h64, 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
